// File: rtl/cmp_pkg.sv
// Shared types for the compare_arbiter slice: comparison op codes, FSM
// states and small op-decoding helpers used by the top level.
package cmp_pkg;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_GT = 2'd1,
        CMP_LE = 2'd2,
        CMP_GE = 2'd3
    } cmp_op_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    // GT and LE are evaluated as b < a, so their operands are swapped.
    function automatic logic op_swaps(input cmp_op_t op);
        return (op == CMP_GT) || (op == CMP_LE);
    endfunction

    // LE and GE are the complement of a strict less-than.
    function automatic logic op_inverts(input cmp_op_t op);
        return (op == CMP_LE) || (op == CMP_GE);
    endfunction

endpackage

// File: rtl/compare_arbiter_if.sv
// Request/response bundle between comparison clients and compare_arbiter.
//   master : client side  (drives req_valid/req_a/req_b/req_op, rsp_ready)
//   slave  : arbiter side (drives req_ready, rsp_valid/rsp_id/rsp_result)
// Operands are packed per requester: requester i uses [i*N +: N], op [i*2 +: 2].
interface compare_arbiter_if #(
    parameter int unsigned N   = 32,
    parameter int unsigned R   = 4,
    parameter int unsigned IDW = $clog2(R)
);
    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic [R*2-1:0] req_op;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic           rsp_result;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result
    );
endinterface

// File: rtl/comparator_lt.sv
// Signed N-bit strict less-than.
//   i_a, i_b : two's complement operands
//   o_lt     : 1 when i_a < i_b (signed)
module comparator_lt #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic         o_lt
);
    assign o_lt = $signed(i_a) < $signed(i_b);
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register lives in the caller.
//   i_req        : request vector
//   i_last_grant : index granted last; search starts one above it, wrapping
//   i_enable     : when low no grant is issued
//   o_grant      : one-hot grant (or zero)
//   o_grant_idx  : index of the granted requester (0 when none)
module rr_arbiter #(
    parameter int unsigned R   = 4,
    parameter int unsigned IDW = $clog2(R)
) (
    input  logic [R-1:0]   i_req,
    input  logic [IDW-1:0] i_last_grant,
    input  logic           i_enable,
    output logic [R-1:0]   o_grant,
    output logic [IDW-1:0] o_grant_idx
);
    logic           w_found;
    logic [IDW-1:0] w_idx;

    // Scan R positions starting just after the last grant; first hit wins.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int unsigned k = 1; k <= R; k++) begin
            w_idx = IDW'((32'(i_last_grant) + k) % R);
            if (i_enable && !w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end
endmodule

// File: rtl/compare_arbiter.sv
// Shares one signed comparator between R requesters with round-robin
// arbitration; one comparison in flight, result returned tagged with the id.
//   clk : clock
//   rst : synchronous reset, active-low
//   bus : compare_arbiter_if.slave (request valid/ready, packed operands/ops,
//         response valid/ready/id/result)
module compare_arbiter
    import cmp_pkg::*;
#(
    parameter int unsigned N   = 32,
    parameter int unsigned R   = 4,
    parameter int unsigned IDW = $clog2(R)
) (
    input  logic              clk,
    input  logic              rst,
    compare_arbiter_if.slave  bus
);
    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    cmp_op_t        r_op;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] r_last_grant;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic           r_rsp_result;

    logic [R-1:0]   w_grant;
    logic [IDW-1:0] w_grant_idx;
    logic           w_arb_en;
    logic           w_accept;
    logic           w_load_rsp;
    logic           w_rsp_fire;
    logic [N-1:0]   w_cmp_a;
    logic [N-1:0]   w_cmp_b;
    logic           w_lt;
    logic           w_result;

    logic [N-1:0]   w_a_arr  [R];
    logic [N-1:0]   w_b_arr  [R];
    logic [1:0]     w_op_arr [R];

    // Unpack the flat request buses so the grant index can select directly.
    for (genvar i = 0; i < R; i++) begin : g_unpack
        assign w_a_arr[i]  = bus.req_a[i*N +: N];
        assign w_b_arr[i]  = bus.req_b[i*N +: N];
        assign w_op_arr[i] = bus.req_op[i*2 +: 2];
    end

    rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .i_enable     (w_arb_en),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx)
    );

    comparator_lt #(.N(N)) u_cmp (
        .i_a  (w_cmp_a),
        .i_b  (w_cmp_b),
        .o_lt (w_lt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept)   w_next = S_COMPARE;
            S_COMPARE:                 w_next = S_RESPOND;
            S_RESPOND: if (w_rsp_fire) w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    // FSM outputs: arbitration enable and register load strobes.
    always_comb begin
        w_arb_en   = 1'b0;
        w_load_rsp = 1'b0;
        w_rsp_fire = 1'b0;
        case (r_state)
            S_IDLE:    w_arb_en   = 1'b1;
            S_COMPARE: w_load_rsp = 1'b1;
            S_RESPOND: w_rsp_fire = r_rsp_valid & bus.rsp_ready;
            default:   ;
        endcase
        w_accept = |w_grant;
    end

    // Operand routing: GT/LE compare swapped operands, LE/GE invert the result.
    always_comb begin
        w_cmp_a  = op_swaps(r_op) ? r_b : r_a;
        w_cmp_b  = op_swaps(r_op) ? r_a : r_b;
        w_result = op_inverts(r_op) ? ~w_lt : w_lt;
    end

    // Request capture, rr pointer and registered response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= CMP_LT;
            r_id         <= '0;
            r_last_grant <= IDW'(R - 1);
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a          <= w_a_arr[w_grant_idx];
                r_b          <= w_b_arr[w_grant_idx];
                r_op         <= cmp_op_t'(w_op_arr[w_grant_idx]);
                r_id         <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if (w_load_rsp) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_id     <= r_id;
                r_rsp_result <= w_result;
            end else if (w_rsp_fire) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = w_grant;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_result = r_rsp_result;

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed bench for compare_arbiter: reset, signed ops at the extremes,
// round-robin order, response backpressure and reset during a compare.
module tb_compare_arbiter;
    import cmp_pkg::*;

    localparam int unsigned N = 32;
    localparam int unsigned R = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    compare_arbiter_if #(.N(N), .R(R)) bus ();

    compare_arbiter #(.N(N), .R(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_req(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                           input cmp_op_t op);
        bus.req_a[id*N +: N]  = a;
        bus.req_b[id*N +: N]  = b;
        bus.req_op[id*2 +: 2] = op;
        bus.req_valid[id]     = 1'b1;
    endtask

    // Bounded wait (from just after a negedge) until requester id is granted.
    task automatic wait_grant(input int id, output bit ok);
        int cnt = 0;
        while (!bus.req_ready[id] && cnt < 12) begin
            @(negedge clk); #1;
            cnt++;
        end
        ok = bus.req_ready[id];
    endtask

    // One request with rsp_ready high; checks latency, id and result.
    task automatic single(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                          input cmp_op_t op, input logic exp, input string tag);
        bit ok;
        set_req(id, a, b, op);
        #1;
        wait_grant(id, ok);
        check({tag, "_gnt"}, 64'(ok), 64'd1);
        if (!ok) begin
            bus.req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
        check({tag, "_t1_valid"}, 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        check({tag, "_t2_valid"}, 64'(bus.rsp_valid), 64'd1);
        check({tag, "_id"}, 64'(bus.rsp_id), 64'(id));
        check({tag, "_res"}, 64'(bus.rsp_result), 64'(exp));
        @(negedge clk);
    endtask

    function automatic int onehot_idx(input logic [R-1:0] v);
        int idx = -1;
        for (int i = 0; i < int'(R); i++) if (v[i]) idx = i;
        return idx;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  exp_order [10] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 2};
        int  cnt;
        bit  ok;

        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b1;

        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        @(negedge clk);

        // Overflow-sensitive extremes
        single(0, 32'h7FFFFFFF, 32'h80000000, CMP_LT, 1'b0, "ovf_lt");
        single(0, 32'h7FFFFFFF, 32'h80000000, CMP_GT, 1'b1, "ovf_gt");
        single(1, 32'h80000000, 32'h7FFFFFFF, CMP_LE, 1'b1, "min_le");
        single(1, 32'h80000000, 32'h80000000, CMP_GE, 1'b1, "min_ge");
        single(1, 32'h80000000, 32'h7FFFFFFF, CMP_GT, 1'b0, "min_gt");

        // Op coverage on requester 2
        single(2, 32'hFFFFFFFB, 32'hFFFFFFFB, CMP_LT, 1'b0, "eq_lt");
        single(2, 32'hFFFFFFFB, 32'hFFFFFFFB, CMP_GT, 1'b0, "eq_gt");
        single(2, 32'hFFFFFFFB, 32'hFFFFFFFB, CMP_LE, 1'b1, "eq_le");
        single(2, 32'hFFFFFFFB, 32'hFFFFFFFB, CMP_GE, 1'b1, "eq_ge");
        single(2, 32'hFFFFFFFA, 32'h00000003, CMP_LT, 1'b1, "neg_lt");
        single(2, 32'hFFFFFFFA, 32'h00000003, CMP_GE, 1'b0, "neg_ge");

        // Fresh pointer, then round-robin with all requesters valid
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < int'(R); i++) set_req(i, N'(i), 32'd2, CMP_LT);
        #1;
        for (int k = 0; k < 10; k++) begin
            cnt = 0;
            while (bus.req_ready == '0 && cnt < 12) begin
                @(negedge clk); #1;
                cnt++;
            end
            check($sformatf("rr_%0d_onehot", k), 64'($countones(bus.req_ready)), 64'd1);
            check($sformatf("rr_%0d_order", k), 64'(onehot_idx(bus.req_ready)), 64'(exp_order[k]));
            @(posedge clk);
            @(negedge clk);
            if (k == 5) bus.req_valid[1] = 1'b0;
            #1;
        end
        bus.req_valid = '0;
        repeat (3) @(negedge clk);

        // Backpressure: response held while rsp_ready is low
        bus.rsp_ready = 1'b0;
        set_req(0, 32'd1, 32'd2, CMP_LT);
        set_req(2, 32'd5, 32'd5, CMP_GE);
        #1;
        wait_grant(0, ok);
        check("bp_gnt0", 64'(ok), 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        #1;
        check("bp_compare_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_%0d_valid", i), 64'(bus.rsp_valid), 64'd1);
            check($sformatf("bp_%0d_id", i), 64'(bus.rsp_id), 64'd0);
            check($sformatf("bp_%0d_res", i), 64'(bus.rsp_result), 64'd1);
            check($sformatf("bp_%0d_ready", i), 64'(bus.req_ready), 64'd0);
            @(negedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        check("bp_next_grant", 64'(bus.req_ready), 64'h4);
        check("bp_released", 64'(bus.rsp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        @(negedge clk); #1;
        check("bp2_valid", 64'(bus.rsp_valid), 64'd1);
        check("bp2_id", 64'(bus.rsp_id), 64'd2);
        check("bp2_res", 64'(bus.rsp_result), 64'd1);
        @(negedge clk);

        // Reset while a compare is in flight
        set_req(1, 32'd1, 32'd9, CMP_LT);
        #1;
        wait_grant(1, ok);
        check("mr_gnt1", 64'(ok), 64'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("mr_%0d_no_rsp", i), 64'(bus.rsp_valid), 64'd0);
            @(negedge clk);
        end
        set_req(1, 32'd1, 32'd2, CMP_LT);
        set_req(3, 32'd1, 32'd2, CMP_LT);
        #1;
        check("mr_ptr_grant", 64'(bus.req_ready), 64'h2);
        bus.req_valid = '0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
